// File: rtl/fifo_pkg.sv
// Shared types and constants for the handshake FIFO family.
package fifo_pkg;

   localparam int FIFO_DATA_W_DEF = 8;
   localparam int FIFO_DEPTH_DEF  = 16;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_ACK  = 1'b1
   } wr_state_t;

   // Address width for a given depth, never narrower than one bit.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Zero read latency; no flow control of its own.
module fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/handshake_fifo.sv
// FIFO with four-phase valid/ack write side and first-word-fall-through read side.
// Write-to-read latency 1 cycle; a write stalls in IDLE (no ack) while full unless a pop frees space.
// Optional synchronous flush input when HANDSHAKE_FIFO_FLUSH_EN is defined.
module handshake_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_W    = FIFO_DATA_W_DEF,
   parameter int DEPTH     = FIFO_DEPTH_DEF,
   parameter int AFULL_LVL = DEPTH - 2
) (
   input  logic                      clk,
   input  logic                      rst,
`ifdef HANDSHAKE_FIFO_FLUSH_EN
   input  logic                      flush,
`endif
   input  logic [DATA_W-1:0]         data_in,
   input  logic                      data_in_valid,
   output logic                      data_in_ack,
   output logic [DATA_W-1:0]         data_out,
   output logic                      data_out_valid,
   input  logic                      data_out_read,
   output logic [addr_w(DEPTH):0]    level,
   output logic                      full,
   output logic                      almost_full,
   output logic                      underflow_err
);

   localparam int AW = addr_w(DEPTH);
   localparam int LW = AW + 1;

   wr_state_t         wr_state;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     level_nxt;
   logic [DATA_W-1:0] rd_data;
   logic              flush_i;
   logic              pop;
   logic              cap;

`ifdef HANDSHAKE_FIFO_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign pop = data_out_valid & data_out_read & ~flush_i;
   assign cap = (wr_state == WR_IDLE) & data_in_valid & (~full | pop) & ~flush_i;

   always_comb begin
      level_nxt = level;
      if (flush_i)
         level_nxt = '0;
      else if (cap && !pop)
         level_nxt = level + 1'b1;
      else if (pop && !cap)
         level_nxt = level - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state       <= WR_IDLE;
         data_in_ack    <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         data_out_valid <= 1'b0;
         full           <= 1'b0;
         almost_full    <= 1'b0;
         underflow_err  <= 1'b0;
      end else begin
         case (wr_state)
            WR_IDLE: if (cap) begin
               wr_state    <= WR_ACK;
               data_in_ack <= 1'b1;
            end
            WR_ACK: if (!data_in_valid) begin
               wr_state    <= WR_IDLE;
               data_in_ack <= 1'b0;
            end
            default: begin
               wr_state    <= WR_IDLE;
               data_in_ack <= 1'b0;
            end
         endcase

         if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (cap) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
         end

         // Flags derive from the next level so they agree with it every cycle.
         level          <= level_nxt;
         data_out_valid <= (level_nxt != '0);
         full           <= (level_nxt == LW'(DEPTH));
         almost_full    <= (level_nxt >= LW'(AFULL_LVL));

         if (data_out_read && !data_out_valid) underflow_err <= 1'b1;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (cap),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   assign data_out = data_out_valid ? rd_data : '0;

endmodule

// File: tb/tb_handshake_fifo.sv
// Directed scoreboard bench for handshake_fifo (DEPTH 16, AFULL_LVL 14, DATA_W 8).
module tb_handshake_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = '0;
   logic       data_in_valid = 1'b0;
   logic       data_in_ack;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_read = 1'b0;
   logic [4:0] level;
   logic       full;
   logic       almost_full;
   logic       underflow_err;
`ifdef HANDSHAKE_FIFO_FLUSH_EN
   logic       flush = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   handshake_fifo #(
      .DATA_W    (8),
      .DEPTH     (16),
      .AFULL_LVL (14)
   ) dut (
      .clk            (clk),
      .rst            (rst),
`ifdef HANDSHAKE_FIFO_FLUSH_EN
      .flush          (flush),
`endif
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_in_ack    (data_in_ack),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_read  (data_out_read),
      .level          (level),
      .full           (full),
      .almost_full    (almost_full),
      .underflow_err  (underflow_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full handshake for one word; ack must arrive exactly one cycle after valid rises.
   task automatic do_write(input logic [7:0] w);
      int n;
      n = 0;
      data_in       = w;
      data_in_valid = 1'b1;
      do begin
         tick();
         n++;
      end while (!data_in_ack && n < 40);
      chk("ack_latency", n, 1);
      exp_q.push_back(w);
      data_in_valid = 1'b0;
      tick();
      chk("ack_drop", data_in_ack, 1'b0);
   endtask

   task automatic check_head(input string tag);
      if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
      else chk(tag, data_out, exp_q[0]);
   endtask

   // Hold read high while valid; every cycle must deliver the scoreboard head.
   task automatic drain(input int exp_cnt);
      int n;
      n = 0;
      data_out_read = 1'b1;
      while (data_out_valid && n < 40) begin
         check_head("drain_data");
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         tick();
         n++;
      end
      data_out_read = 1'b0;
      chk("drain_count", n, exp_cnt);
      chk("drain_valid", data_out_valid, 1'b0);
      chk("drain_level", level, 0);
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_ack", data_in_ack, 1'b0);
      chk("rst_valid", data_out_valid, 1'b0);
      chk("rst_data", data_out, 8'h00);
      chk("rst_level", level, 0);
      chk("rst_full", full, 1'b0);
      chk("rst_afull", almost_full, 1'b0);
      chk("rst_uflow", underflow_err, 1'b0);

      // Reset and write
      do_write(8'd1);
      chk("w1_valid", data_out_valid, 1'b1);
      check_head("w1_head");
      do_write(8'd2);
      chk("w2_level", level, 2);
      check_head("w2_head");

      // Write during pop
      check_head("wp_head_before");
      data_in       = 8'd3;
      data_in_valid = 1'b1;
      data_out_read = 1'b1;
      tick();
      data_out_read = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(8'd3);
      chk("wp_ack", data_in_ack, 1'b1);
      chk("wp_level", level, 2);
      check_head("wp_head_after");
      data_in_valid = 1'b0;
      tick();

      // Fill and drain in order
      for (int i = 4; i <= 7; i++) do_write(8'(i));
      chk("fill_level", level, 6);
      drain(6);
      chk("fill_uflow", underflow_err, 1'b0);

      // Full and stall
      for (int i = 0; i < 16; i++) begin
         do_write(8'(i));
         chk("lvl_afull", almost_full, (i + 1) >= 14);
         chk("lvl_full", full, (i + 1) == 16);
      end
      data_in       = 8'd16;
      data_in_valid = 1'b1;
      tick();
      tick();
      tick();
      chk("stall_ack", data_in_ack, 1'b0);
      chk("stall_level", level, 16);
      check_head("stall_head");
      data_out_read = 1'b1;
      tick();
      data_out_read = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(8'd16);
      chk("unstall_ack", data_in_ack, 1'b1);
      chk("unstall_level", level, 16);
      chk("unstall_full", full, 1'b1);
      check_head("unstall_head");
      data_in_valid = 1'b0;
      tick();
      drain(16);

      // Underflow is sticky until reset
      data_out_read = 1'b1;
      tick();
      data_out_read = 1'b0;
      chk("uflow_set", underflow_err, 1'b1);
      chk("uflow_level", level, 0);
      tick();
      tick();
      chk("uflow_sticky", underflow_err, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("uflow_rst", underflow_err, 1'b0);

`ifdef HANDSHAKE_FIFO_FLUSH_EN
      for (int i = 0; i < 5; i++) do_write(8'(8'h10 + i));
      chk("pre_flush_level", level, 5);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_q.delete();
      chk("flush_level", level, 0);
      chk("flush_valid", data_out_valid, 1'b0);
      do_write(8'hA5);
      check_head("flush_rd");
      drain(1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/handshake_fifo.md
# handshake_fifo

Parametrised successor to the 8-bit single-channel `Buffer`, with configurable data width and depth.
- Write side: four-phase valid/ack handshake (producer holds valid until ack, then drops it).
- Read side: first-word-fall-through valid/read interface that can drain one word per cycle.
- Adds occupancy, full and almost-full status, and a sticky underflow flag.
- Sits between sample producers (ADC/serial front ends) and downstream processing.

## Interface
- `DATA_W`, default 8: word width in bits.
- `DEPTH`, default 16: storage words; power of two, ≥ 2.
- `AFULL_LVL`, default `DEPTH-2`: `almost_full` asserts when `level` ≥ this value; range 1..`DEPTH`.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  `DATA_W`  write word; sampled in the capture cycle.
- `data_in_valid`  in  1  write request; producer holds it high until `data_in_ack`.
- `data_in_ack`  out  1  asserted after capture; held until `data_in_valid` falls.
- `data_out`  out  `DATA_W`  head word; meaningful while `data_out_valid` is high.
- `data_out_valid`  out  1  FIFO not empty.
- `data_out_read`  in  1  pop request; honoured only when `data_out_valid` is high.
- `level`  out  `$clog2(DEPTH)+1`  current occupancy, 0..`DEPTH`.
- `full`  out  1  `level == DEPTH`.
- `almost_full`  out  1  `level >= AFULL_LVL`.
- `underflow_err`  out  1  sticky; set by a read while empty, cleared only by `rst`.

## Operation
Write FSM states:
- **IDLE**
  - If `data_in_valid` is high and there is space: capture `data_in`, go to ACK.
  - "Space" means `!full`, or `full` with a pop in the same cycle.
  - Otherwise stay in IDLE; the producer waits and nothing is lost.
- **ACK**
  - `data_in_ack` = 1.
  - No capture occurs while in ACK.
  - When `data_in_valid` = 0 is sampled, return to IDLE.

Read side:
- A pop happens when `data_out_valid & data_out_read`. The read pointer advances; the next word (if any) appears the following cycle.
- Holding `data_out_read` high drains one word per cycle.
- A read while empty changes no state except setting `underflow_err`.

Pointers and occupancy:
- Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH` naturally.
- `level` is a separate counter: +1 on capture only, −1 on pop only, unchanged when both occur in the same cycle.
- With simultaneous capture and pop at `level` = 0: not allowed (there is no valid head), so it is capture only.
- Word order is strictly FIFO.

## Timing
- Reset values: `data_in_ack` = 0, `data_out_valid` = 0, `data_out` = 0, `level` = 0, `full` = 0, `almost_full` = 0, `underflow_err` = 0. FSM resets to IDLE and both pointers to 0.
- Reset mid-operation: stored contents are discarded. If `data_in_valid` is still high after reset, the word is captured again on the first post-reset cycle.
- Write capture at edge k:
  - `data_in_ack` is high from k+1.
  - If the FIFO was empty, `data_out_valid` and `data_out` are valid from k+1 (write-to-read latency 1 cycle).
  - `level` updates at k+1.
- `data_in_ack` falls on the edge after `data_in_valid` is sampled low. Minimum write period is 3 cycles (capture, ACK with valid low, IDLE).
- `full`, `almost_full` and `data_out_valid` are registered and consistent with `level` in the same cycle.
- Pop at edge k: `data_out` shows the next word from k+1; `data_out_valid` drops at k+1 if `level` becomes 0.

## Configuration
Macro `HANDSHAKE_FIFO_FLUSH_EN`:
- **Defined:** adds input port `flush` (1 bit).
- While `flush` is high:
  - Pointers and `level` reset to 0 and `data_out_valid` clears on the next edge.
  - Pops and captures in that cycle are ignored.
  - The write FSM still completes an ACK in progress.
- `underflow_err` is not cleared by `flush`.
- **Undefined:** no `flush` port; only `rst` empties the FIFO.

## Structure
- Shared package `fifo_pkg`:
  - write FSM state enum (`WR_IDLE`, `WR_ACK`);
  - a `clog2`-based width helper;
  - default constants `FIFO_DATA_W_DEF` = 8, `FIFO_DEPTH_DEF` = 16.
- One sub-module, `fifo_mem`: a simple dual-port register array (`DATA_W` × `DEPTH`) with synchronous write and asynchronous read by address. The top level owns the pointers, level counter, FSM and flags.

## Test plan
- **Reset and write:** pulse `rst` 1 cycle, then write 1 and 2 through the handshake.
  - `data_in_ack` is high one cycle after each capture.
  - `level` = 2, `data_out` = 1, `data_out_valid` = 1.
- **Write during pop:** with 1,2 stored, raise `data_in_valid` (3) and `data_out_read` together for one cycle.
  - 1 is popped and 3 captured; `level` stays 2; `data_out` shows 2.
- **Fill:** write 4, 5, 6, 7, then hold `data_out_read` high.
  - Outputs appear one per cycle in order 2,3,4,5,6,7.
  - `data_out_valid` falls after 7; `level` = 0; `underflow_err` stays 0.
- **Full and stall:** `DEPTH` = 16, `AFULL_LVL` = 14; write 0..16 with no reads.
  - `almost_full` rises at `level` 14 and `full` at 16.
  - The 17th word (16) stalls: no ack while full.
  - One pop then yields `data_out` = 0, after which 16 is captured and `level` returns to 16.
- **Underflow:** assert `data_out_read` while empty.
  - `underflow_err` rises next cycle and stays high until `rst`.
  - `level` stays 0.
- **Flush (`HANDSHAKE_FIFO_FLUSH_EN`):** with 5 words stored, pulse `flush`.
  - Next cycle `level` = 0 and `data_out_valid` = 0.
  - A subsequent write of 0xA5 reads back as 0xA5.
